// File: rtl/aluctrl_pkg.sv
// Shared encodings for the execute-stage ALU controller: decode-side aluop,
// base ALU codes, RV32M funct3 codes, FSM states and the base-code decoder.
package aluctrl_pkg;

  typedef enum logic [1:0] {
    AOP_ADD = 2'b00,  // loads/stores: address add
    AOP_BR  = 2'b01,  // branches: unsigned compare
    AOP_R   = 2'b10,  // R-type, funct3/funct7 decoded
    AOP_I   = 2'b11   // I-type, funct7 is imm[11:5]
  } aluop_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_code_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } mop_e;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // I-type only honours funct7[5] for shifts-right so ADDI never turns into SUB.
  function automatic logic [3:0] base_code(input logic [1:0] aluop,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
    case (aluop)
      AOP_ADD: base_code = ALU_ADD;
      AOP_BR:  base_code = ALU_SLTU;
      AOP_R:   base_code = {f7[5], f3};
      default: base_code = {f7[5] & (f3 == 3'b101), f3};
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide engine: one product or quotient bit per
// cycle on operand magnitudes. Sign handling lives in the parent.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi_nxt,
  output logic [XLEN-1:0] o_lo_nxt,
  output logic            o_done
);
  localparam int CW = $clog2(XLEN);

  // hi: product high half / partial remainder; lo: multiplier / dividend->quotient
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic            r_div, r_run;
  logic [CW-1:0]   r_cnt;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shl;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  // Last iteration is flagged combinationally so the parent can capture the
  // final value on the same edge the registers would take it.
  assign o_done = r_run & (r_cnt == CW'(XLEN - 1));

  // One shift-add or restoring-subtract step from the current registers
  always_comb begin
    w_sum    = '0;
    w_shl    = '0;
    w_sub    = '0;
    w_ge     = 1'b0;
    o_hi_nxt = r_hi;
    o_lo_nxt = r_lo;
    if (r_div) begin
      w_shl = {r_hi, r_lo[XLEN-1]};
      w_ge  = w_shl >= {1'b0, r_b};
      // when w_ge holds, the difference is below the divisor and fits XLEN bits
      w_sub = w_shl[XLEN-1:0] - r_b;
      if (w_ge) begin
        o_hi_nxt = w_sub;
        o_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi_nxt = w_shl[XLEN-1:0];
        o_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      o_hi_nxt = w_sum[XLEN:1];
      o_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Load on start, then iterate XLEN times
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_div <= i_is_div;
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/aluctrl_seq.sv
// Execute-stage ALU controller: decodes aluop/funct3/funct7 (incl. RV32M),
// computes base ops in one cycle, runs MUL/DIV on mdu_iter, and holds the
// registered result for writeback behind a valid/ready handshake.
module aluctrl_seq
  import aluctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      ctrl_aluop_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state, w_state_nxt, w_acc_state;
  logic              w_accept, w_is_m, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b;
  logic              w_div_zero, w_div_ovf;
  logic [2:0]        w_mop;
  logic [3:0]        w_code;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_base_res, w_fast_res;

  logic [2:0]        r_mop;
  logic              r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_result;

  logic [XLEN-1:0]   w_mdu_hi, w_mdu_lo, w_mdu_res;
  logic              w_mdu_done;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept = valid_i & ready_o;
  assign result_o = r_result;

  // Decode, base ALU, operand magnitudes and one-cycle divide special cases
  always_comb begin
    w_is_m  = (ctrl_aluop_i == AOP_R) && (funct7_i == F7_MEXT);
    w_mop   = funct3_i;
    w_code  = base_code(ctrl_aluop_i, funct3_i, funct7_i);
    w_shamt = op_b_i[SHW-1:0];

    case (w_code)
      ALU_SUB:  w_base_res = op_a_i - op_b_i;
      ALU_SLL:  w_base_res = op_a_i << w_shamt;
      ALU_SLT:  w_base_res = {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      ALU_SLTU: w_base_res = {{(XLEN-1){1'b0}}, op_a_i < op_b_i};
      ALU_XOR:  w_base_res = op_a_i ^ op_b_i;
      ALU_SRL:  w_base_res = op_a_i >> w_shamt;
      ALU_SRA:  w_base_res = $signed(op_a_i) >>> w_shamt;
      ALU_OR:   w_base_res = op_a_i | op_b_i;
      ALU_AND:  w_base_res = op_a_i & op_b_i;
      default:  w_base_res = op_a_i + op_b_i;  // ADD and undefined codes
    endcase

    // signed divides have funct3[0]==0; MULHSU treats only rs1 as signed
    if (w_mop[2]) begin
      w_a_sgn = ~w_mop[0];
      w_b_sgn = ~w_mop[0];
    end else begin
      w_a_sgn = (w_mop != M_MULHU);
      w_b_sgn = (w_mop == M_MUL) || (w_mop == M_MULH);
    end
    w_neg_a = w_a_sgn & op_a_i[XLEN-1];
    w_neg_b = w_b_sgn & op_b_i[XLEN-1];
    w_mag_a = w_neg_a ? -op_a_i : op_a_i;
    w_mag_b = w_neg_b ? -op_b_i : op_b_i;

    w_div_zero = (op_b_i == '0);
    w_div_ovf  = ~w_mop[0] & (op_a_i == MIN_VAL) & (op_b_i == '1);

    w_fast_res = w_base_res;
    if (w_is_m) begin
      if (w_mop[1]) w_fast_res = w_div_zero ? op_a_i : '0;      // REM/REMU
      else          w_fast_res = w_div_zero ? '1 : MIN_VAL;     // DIV/DIVU
    end

    if (!w_is_m)                      w_acc_state = ST_DONE;
    else if (!w_mop[2])               w_acc_state = ST_MUL;
    else if (w_div_zero || w_div_ovf) w_acc_state = ST_DONE;
    else                              w_acc_state = ST_DIV;
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .i_clk    (clk_i),
    .i_rst_n  (rst_n_i),
    .i_start  (w_accept && (w_acc_state != ST_DONE)),
    .i_is_div (w_mop[2]),
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_hi_nxt (w_mdu_hi),
    .o_lo_nxt (w_mdu_lo),
    .o_done   (w_mdu_done)
  );

  // Sign post-correction of the engine's final value
  always_comb begin
    w_prod = {w_mdu_hi, w_mdu_lo};
    if (r_neg_q) w_prod = -w_prod;
    if (r_mop[2]) begin
      if (r_mop[1]) w_mdu_res = r_neg_r ? -w_mdu_hi : w_mdu_hi;
      else          w_mdu_res = r_neg_q ? -w_mdu_lo : w_mdu_lo;
    end else begin
      w_mdu_res = (r_mop == M_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; DONE can chain straight into a newly accepted op
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:        if (w_accept) w_state_nxt = w_acc_state;
      ST_MUL, ST_DIV: if (w_mdu_done) w_state_nxt = ST_DONE;
      ST_DONE:        if (result_ready_i) w_state_nxt = w_accept ? w_acc_state : ST_IDLE;
      default:        w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_o        = (r_state == ST_IDLE) || ((r_state == ST_DONE) && result_ready_i);
    result_valid_o = (r_state == ST_DONE);
    busy_o         = (r_state == ST_MUL) || (r_state == ST_DIV);
  end

  // Result register and sign flags captured for the iterative path
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_result <= '0;
      r_mop    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mop   <= w_mop;
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
      end
      if (w_accept && (w_acc_state == ST_DONE)) r_result <= w_fast_res;
      else if (w_mdu_done)                      r_result <= w_mdu_res;
    end
  end

endmodule

// File: tb/tb_aluctrl_seq.sv
// Directed plus random bench for aluctrl_seq against a plain-arithmetic model.
module tb_aluctrl_seq;
  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  ctrl_aluop_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  aluctrl_seq #(.XLEN(XLEN)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .ctrl_aluop_i   (ctrl_aluop_i),
    .funct3_i       (funct3_i),
    .funct7_i       (funct7_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: what the instruction means, in plain arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, zb;
    logic [63:0] ua, ub, p;
    logic alt, ovf;
    int unsigned sh;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    zb = ub;
    sh = b[4:0];
    ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return (a < b) ? 32'd1 : 32'd0;
    if (op == 2'b10 && f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = sa * sb; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * zb; return p[63:32]; end
        3'd3: begin p = ua * ub; return p[63:32]; end
        3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? MINV : 32'($signed(a) / $signed(b));
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
        default: return (b == 0) ? a : a % b;
      endcase
    end
    alt = (op == 2'b10) ? f7[5] : (f7[5] && f3 == 3'b101);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return alt ? a + b : a << sh;
      3'd2: return alt ? a + b : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
      3'd3: return alt ? a + b : ((a < b) ? 32'd1 : 32'd0);
      3'd4: return alt ? a + b : a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return alt ? a + b : a | b;
      default: return alt ? a + b : a & b;
    endcase
  endfunction

  // Cycles from accept to result_valid
  function automatic int ref_lat(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!(op == 2'b10 && f7 == 7'h01)) return 1;
    if (f3[2] == 1'b0) return XLEN + 1;
    if (b == 0) return 1;
    if (f3[0] == 1'b0 && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    ctrl_aluop_i = op; funct3_i = f3; funct7_i = f7; op_a_i = a; op_b_i = b;
    valid_i = 1'b1;
  endtask

  // Issue one op from IDLE, check latency, busy length and value, then consume
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int nbusy;
    drive(op, f3, f7, a, b);
    #1;
    chk({tag, "/ready"}, 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!result_valid_o && lat < 100) begin
      if (busy_o) nbusy++;
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/busy"}, 32'(nbusy), (exp_lat > 1) ? 32'(XLEN) : 32'd0);
    chk({tag, "/res"}, result_o, exp_res);
    result_ready_i = 1'b1;
    @(posedge clk_i); #1;
    result_ready_i = 1'b0;
  endtask

  logic [1:0]  r_op;
  logic [2:0]  r_f3;
  logic [6:0]  r_f7;
  logic [31:0] r_a, r_b, held, e_prev;

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    chk("rst/ready", 32'(ready_o), 32'd1);
    chk("rst/valid", 32'(result_valid_o), 32'd0);
    chk("rst/busy", 32'(busy_o), 32'd0);
    chk("rst/result", result_o, 32'd0);

    // Directed
    run_op("addi",   2'b11, 3'b000, 7'h20, 32'd5, 32'd3, 32'd8, 1);
    run_op("sra",    2'b10, 3'b101, 7'h20, MINV, 32'd4, 32'hF800_0000, 1);
    run_op("srl",    2'b10, 3'b101, 7'h00, MINV, 32'd4, 32'h0800_0000, 1);
    run_op("sltu",   2'b01, 3'b000, 7'h00, 32'd3, 32'hFFFF_FFFF, 32'd1, 1);
    run_op("ld_add", 2'b00, 3'b010, 7'h20, 32'd100, 32'hFFFF_FFFC, 32'd96, 1);
    run_op("undef",  2'b10, 3'b001, 7'h20, 32'd9, 32'd4, 32'd13, 1);
    run_op("mulh",   2'b10, 3'b001, 7'h01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
    run_op("mulhu",  2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
    run_op("mul",    2'b10, 3'b000, 7'h01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
    run_op("div0",   2'b10, 3'b100, 7'h01, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu0",  2'b10, 3'b111, 7'h01, 32'd7, 32'd0, 32'd7, 1);
    run_op("removf", 2'b10, 3'b110, 7'h01, MINV, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divovf", 2'b10, 3'b100, 7'h01, MINV, 32'hFFFF_FFFF, MINV, 1);
    run_op("div",    2'b10, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",    2'b10, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

    // Stalled result stays put; release overlaps with a new accept
    drive(2'b00, 3'b000, 7'h00, 32'd11, 32'd22);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("stall/first", result_o, 32'd33);
    held = result_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("stall/hold", result_o, held);
      chk("stall/ready", 32'(ready_o), 32'd0);
      chk("stall/valid", 32'(result_valid_o), 32'd1);
    end
    drive(2'b00, 3'b000, 7'h00, 32'd40, 32'd2);
    result_ready_i = 1'b1;
    #1;
    chk("stall/rel_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("stall/next_valid", 32'(result_valid_o), 32'd1);
    chk("stall/next_res", result_o, 32'd42);
    @(posedge clk_i); #1;
    result_ready_i = 1'b0;
    chk("stall/drained", 32'(result_valid_o), 32'd0);

    // Back-to-back base ops, one result per cycle
    result_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_f3 = 3'($urandom);
      r_f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      r_a = $urandom; r_b = $urandom;
      e_prev = ref_res(r_op, r_f3, r_f7, r_a, r_b);
      drive(r_op, r_f3, r_f7, r_a, r_b);
      @(posedge clk_i); #1;
      chk("b2b/valid", 32'(result_valid_o), 32'd1);
      chk("b2b/res", result_o, e_prev);
    end
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    result_ready_i = 1'b0;
    chk("b2b/idle", 32'(result_valid_o), 32'd0);

    // Reset in the middle of a divide
    drive(2'b10, 3'b100, 7'h01, 32'd1000, 32'd7);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    #2;
    chk("rstmid/busy", 32'(busy_o), 32'd0);
    rst_n_i = 1'b1;
    #1;
    chk("rstmid/valid", 32'(result_valid_o), 32'd0);
    chk("rstmid/ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      chk("rstmid/no_result", 32'(result_valid_o), 32'd0);
    end
    run_op("after_rst", 2'b10, 3'b100, 7'h01, 32'd100, 32'd7, 32'd14, 33);

    // Random ops against the model
    for (int n = 0; n < 50; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: r_f7 = 7'h00;
        1: r_f7 = 7'h20;
        2: r_f7 = 7'h01;
        default: r_f7 = 7'($urandom);
      endcase
      if (n % 3 == 0) begin r_op = 2'b10; r_f7 = 7'h01; end
      r_a = $urandom; r_b = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = MINV; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rand", r_op, r_f3, r_f7, r_a, r_b,
             ref_res(r_op, r_f3, r_f7, r_a, r_b), ref_lat(r_op, r_f3, r_f7, r_a, r_b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
